axi_lite_cmd_frontend: RTL

- AXI4-Lite slave front end of the AXI-to-APB bridge, one stage upstream of the APB master FSM. Runs entirely in the pclk domain.
- Accepts AW+W pairs and AR requests, arbitrates between them and queues commands {write, addr, wdata} in a show-ahead command FIFO that the APB FSM drains.
- Captures each APB completion (fifo_pop, PRDATA) into an in-order response FIFO and returns it on B or R.

---
 rtl/bridge_pkg.sv | 35 +++
 rtl/bridge_sync_fifo.sv | 59 +++++
 rtl/axi_lite_cmd_frontend.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bridge_pkg
// Description : Shared types and constants for the AXI4-Lite to APB bridge.
//               cmd_t travels from the AXI front end to the APB master FSM;
//               rsp_t carries each APB completion back to the B/R channels.
//               CMD_ADDR_W / CMD_DATA_W fix the packed field widths and are
//               the upper bound for the front end's ADDR_W / DATA_W.
// Revision    : 1.0 - initial release
// ============================================================================
package bridge_pkg;

   localparam int CMD_ADDR_W = 32;
   localparam int CMD_DATA_W = 32;

   localparam logic [1:0] AXI_RESP_OKAY = 2'b00;

   typedef struct packed {
      logic                  write;
      logic [CMD_ADDR_W-1:0] addr;
      logic [CMD_DATA_W-1:0] wdata;
   } cmd_t;

   typedef struct packed {
      logic                  write;
      logic [CMD_DATA_W-1:0] rdata;
   } rsp_t;

   typedef enum logic {
      GNT_WR = 1'b0,
      GNT_RD = 1'b1
   } grant_t;

endpackage
`default_nettype wire

// File: rtl/bridge_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bridge_sync_fifo
// Description : Single-clock show-ahead FIFO. dout presents the head entry
//               combinationally and reads zero while the FIFO is empty.
//               Pointers carry one extra bit so full and empty differ.
// Ports       : pclk, presetn (async, active-low)
//               push/din  - write din when not full
//               pop       - drop head entry when not empty
//               full/empty, dout (head entry)
// Revision    : 1.0 - initial release
// ============================================================================
module bridge_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic             pclk,
   input  logic             presetn,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] dout
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W:0]   r_wr_ptr;
   logic [PTR_W:0]   r_rd_ptr;
   logic             w_push;
   logic             w_pop;

   assign w_push = push & ~full;
   assign w_pop  = pop  & ~empty;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + (PTR_W+1)'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + (PTR_W+1)'(1);
      end
   end

   // Storage needs no reset: empty masks stale contents at dout.
   always_ff @(posedge pclk) begin
      if (w_push) r_mem[r_wr_ptr[PTR_W-1:0]] <= din;
   end

   assign empty = (r_wr_ptr == r_rd_ptr);
   assign full  = (r_wr_ptr[PTR_W] != r_rd_ptr[PTR_W]) &&
                  (r_wr_ptr[PTR_W-1:0] == r_rd_ptr[PTR_W-1:0]);
   assign dout  = empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];

endmodule
`default_nettype wire

// File: rtl/axi_lite_cmd_frontend.sv
`default_nettype none
// ============================================================================
// Module      : axi_lite_cmd_frontend
// Description : AXI4-Lite slave front end of the AXI-to-APB bridge. Accepts
//               AW+W pairs and AR requests (one per cycle, alternating on a
//               tie), queues commands for the APB master and returns APB
//               completions in order on B or R. A credit counter bounds the
//               outstanding transactions to DEPTH so neither FIFO overflows.
// Ports       : pclk, presetn (async, active-low)
//               AXI4-Lite AW/W/B/AR/R channels (no WSTRB, OKAY responses)
//               fifo_empty, cmd_addr, cmd_wdata, cmd_write - head command
//               fifo_pop, PRDATA - APB completion and its read data
// Revision    : 1.0 - initial release
// ============================================================================
module axi_lite_cmd_frontend
   import bridge_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic              pclk,
   input  logic              presetn,
   input  logic              AWVALID,
   output logic              AWREADY,
   input  logic [ADDR_W-1:0] AWADDR,
   input  logic              WVALID,
   output logic              WREADY,
   input  logic [DATA_W-1:0] WDATA,
   output logic              BVALID,
   input  logic              BREADY,
   output logic [1:0]        BRESP,
   input  logic              ARVALID,
   output logic              ARREADY,
   input  logic [ADDR_W-1:0] ARADDR,
   output logic              RVALID,
   input  logic              RREADY,
   output logic [DATA_W-1:0] RDATA,
   output logic [1:0]        RRESP,
   output logic              fifo_empty,
   output logic [ADDR_W-1:0] cmd_addr,
   output logic [DATA_W-1:0] cmd_wdata,
   output logic              cmd_write,
   input  logic              fifo_pop,
   input  logic [DATA_W-1:0] PRDATA
);

   localparam int CNT_W = $clog2(DEPTH) + 1;

   logic [CNT_W-1:0] r_outstanding;
   grant_t           r_last_grant;

   logic w_wr_req, w_rd_req, w_can_accept;
   logic w_grant_wr, w_grant_rd, w_accept;
   logic w_cmd_pop, w_cmd_full, w_cmd_empty;
   logic w_rsp_full, w_rsp_empty, w_rsp_hs;
   cmd_t w_cmd_in, w_cmd_head;
   rsp_t w_rsp_in, w_rsp_head;

   // ---------------- arbitration and credit ----------------
   assign w_wr_req = AWVALID & WVALID;
   assign w_rd_req = ARVALID;
   // Gating with presetn keeps every ready low while reset is held.
   assign w_can_accept = presetn && (r_outstanding < CNT_W'(DEPTH));

   always_comb begin
      w_grant_wr = 1'b0;
      w_grant_rd = 1'b0;
      if (w_can_accept) begin
         if (w_wr_req && w_rd_req) begin
            w_grant_wr = (r_last_grant == GNT_RD);
            w_grant_rd = (r_last_grant == GNT_WR);
         end else begin
            w_grant_wr = w_wr_req;
            w_grant_rd = w_rd_req;
         end
      end
   end

   assign w_accept = w_grant_wr | w_grant_rd;
   assign AWREADY  = w_grant_wr;
   assign WREADY   = w_grant_wr;
   assign ARREADY  = w_grant_rd;

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         r_last_grant  <= GNT_RD;
         r_outstanding <= '0;
      end else begin
         if (w_accept) r_last_grant <= w_grant_wr ? GNT_WR : GNT_RD;
         case ({w_accept, w_rsp_hs})
            2'b10:   r_outstanding <= r_outstanding + CNT_W'(1);
            2'b01:   r_outstanding <= r_outstanding - CNT_W'(1);
            default: r_outstanding <= r_outstanding;
         endcase
      end
   end

   // ---------------- command FIFO ----------------
   always_comb begin
      w_cmd_in.write = w_grant_wr;
      w_cmd_in.addr  = w_grant_wr ? CMD_ADDR_W'(AWADDR) : CMD_ADDR_W'(ARADDR);
      w_cmd_in.wdata = w_grant_wr ? CMD_DATA_W'(WDATA)  : '0;
   end

   bridge_sync_fifo #(.WIDTH($bits(cmd_t)), .DEPTH(DEPTH)) u_cmd_fifo (
      .pclk    (pclk),
      .presetn (presetn),
      .push    (w_accept),
      .pop     (w_cmd_pop),
      .din     (w_cmd_in),
      .full    (w_cmd_full),
      .empty   (w_cmd_empty),
      .dout    (w_cmd_head)
   );

   assign fifo_empty = w_cmd_empty;
   assign cmd_write  = w_cmd_head.write;
   assign cmd_addr   = ADDR_W'(w_cmd_head.addr);
   assign cmd_wdata  = DATA_W'(w_cmd_head.wdata);

   // A pop with nothing queued is dropped so no phantom response appears.
   assign w_cmd_pop = fifo_pop & ~w_cmd_empty;

   // ---------------- response FIFO ----------------
   always_comb begin
      w_rsp_in.write = w_cmd_head.write;
      w_rsp_in.rdata = w_cmd_head.write ? '0 : CMD_DATA_W'(PRDATA);
   end

   bridge_sync_fifo #(.WIDTH($bits(rsp_t)), .DEPTH(DEPTH)) u_rsp_fifo (
      .pclk    (pclk),
      .presetn (presetn),
      .push    (w_cmd_pop),
      .pop     (w_rsp_hs),
      .din     (w_rsp_in),
      .full    (w_rsp_full),
      .empty   (w_rsp_empty),
      .dout    (w_rsp_head)
   );

   assign BVALID   = ~w_rsp_empty &  w_rsp_head.write;
   assign RVALID   = ~w_rsp_empty & ~w_rsp_head.write;
   assign RDATA    = DATA_W'(w_rsp_head.rdata);
   assign BRESP    = AXI_RESP_OKAY;
   assign RRESP    = AXI_RESP_OKAY;
   assign w_rsp_hs = (BVALID & BREADY) | (RVALID & RREADY);

   // ---------------- simulation checks ----------------
   a_pop_when_empty: assert property (@(posedge pclk) disable iff (!presetn)
      !(fifo_pop && w_cmd_empty));
   a_cmd_overflow: assert property (@(posedge pclk) disable iff (!presetn)
      !(w_accept && w_cmd_full));
   a_rsp_overflow: assert property (@(posedge pclk) disable iff (!presetn)
      !(w_cmd_pop && w_rsp_full));

endmodule
`default_nettype wire
